// File: rtl/uart_console_pkg.sv
// Shared definitions for the UART console arbiter: FSM states, UART register
// offsets and the AXI OKAY response code.
package uart_console_pkg;

  typedef enum logic [1:0] {
    ST_CFG  = 2'd0,
    ST_IDLE = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  localparam int unsigned UART_TX_OFFSET   = 0;
  localparam int unsigned UART_BAUD_OFFSET = 4;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;

endpackage

// File: rtl/rr_lock_arbiter.sv
// Combinational round-robin arbiter with an optional lock that restricts the
// candidates to a single owner. Pointer and lock state live in the caller.
module rr_lock_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               lock_en_i,
  input  logic [IDX_W-1:0]   lock_owner_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [NUM_REQ-1:0] cand;
  logic [IDX_W-1:0]   slot;

  // Search upward from the pointer, wrapping, and take the first candidate.
  always_comb begin
    cand    = req_i;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    slot    = '0;
    if (lock_en_i) begin
      cand = req_i & (NUM_REQ'(1) << lock_owner_i);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!valid_o && cand[slot]) begin
        valid_o       = 1'b1;
        grant_o[slot] = 1'b1;
        idx_o         = slot;
      end
    end
  end

endmodule

// File: rtl/uart_console_arbiter.sv
// AXI-Lite write master that programs the UART baud divider after reset and then
// forwards bytes from several producers, one single-beat write per byte.
module uart_console_arbiter
  import uart_console_pkg::*;
#(
  parameter int                    NUM_REQ       = 4,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] UART_BASE     = '0,
  parameter logic [15:0]           BAUD_DIV_INIT = 16'd868
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [8*NUM_REQ-1:0]          req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         M_AXI_awaddr,
  output logic [2:0]                    M_AXI_awprot,
  output logic                          M_AXI_awvalid,
  input  logic                          M_AXI_awready,
  output logic [DATA_WIDTH-1:0]         M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0]       M_AXI_wstrb,
  output logic                          M_AXI_wvalid,
  input  logic                          M_AXI_wready,
  input  logic [1:0]                    M_AXI_bresp,
  input  logic                          M_AXI_bvalid,
  output logic                          M_AXI_bready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          locked,
  output logic                          busy,
  output logic [7:0]                    err_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e                  state_q, state_d;
  logic                    issued_q, issued_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    last_q, last_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic                    locked_q, locked_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]              err_q, err_d;

  logic [NUM_REQ-1:0] arbGrant;
  logic [IDX_W-1:0]   arbIdx;
  logic               arbValid;
  logic [7:0]         selByte;
  logic               selLast;
  logic               awNow, wNow, writeDone;

  rr_lock_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i        (req_valid),
    .lock_en_i    (locked_q),
    .lock_owner_i (grant_q),
    .ptr_i        (rr_ptr_q),
    .grant_o      (arbGrant),
    .idx_o        (arbIdx),
    .valid_o      (arbValid)
  );

  // Valids derive only from registers, so no slave input reaches an AXI output.
  assign M_AXI_awaddr  = awaddr_q;
  assign M_AXI_awprot  = 3'b000;
  assign M_AXI_awvalid = issued_q & ~aw_done_q;
  assign M_AXI_wdata   = wdata_q;
  assign M_AXI_wstrb   = wstrb_q;
  assign M_AXI_wvalid  = issued_q & ~w_done_q;
  assign M_AXI_bready  = issued_q;
  assign req_ready     = (state_q == ST_IDLE) ? arbGrant : '0;
  assign grant_id      = grant_q;
  assign locked        = locked_q;
  assign busy          = (state_q != ST_IDLE);
  assign err_count     = err_q;

  assign awNow     = aw_done_q | (M_AXI_awvalid & M_AXI_awready);
  assign wNow      = w_done_q  | (M_AXI_wvalid  & M_AXI_wready);
  assign writeDone = issued_q & awNow & wNow & M_AXI_bvalid;

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = '1;
    last_d    = last_q;
    grant_d   = grant_q;
    locked_d  = locked_q;
    rr_ptr_d  = rr_ptr_q;
    err_d     = err_q;
    selByte   = '0;
    selLast   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arbIdx == IDX_W'(i)) begin
        selByte = req_data[8*i +: 8];
        selLast = req_last[i];
      end
    end

    case (state_q)
      ST_CFG: begin
        // The first clock after reset launches the baud divider write.
        if (!issued_q) begin
          issued_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awaddr_d  = UART_BASE + ADDR_WIDTH'(UART_BAUD_OFFSET);
          wdata_d   = DATA_WIDTH'({16'h0, BAUD_DIV_INIT});
        end else begin
          aw_done_d = awNow;
          w_done_d  = wNow;
          if (writeDone) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (arbValid) begin
          state_d   = ST_XFER;
          issued_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awaddr_d  = UART_BASE + ADDR_WIDTH'(UART_TX_OFFSET);
          wdata_d   = DATA_WIDTH'({24'h0, selByte});
          last_d    = selLast;
          grant_d   = arbIdx;
          locked_d  = 1'b1;
        end
      end
      ST_XFER: begin
        aw_done_d = awNow;
        w_done_d  = wNow;
        if (writeDone) begin
          state_d = ST_IDLE;
          if (last_q) begin
            locked_d = 1'b0;
            rr_ptr_d = (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = ST_CFG;
    endcase

    if (writeDone) begin
      issued_d = 1'b0;
      if (M_AXI_bresp != RESP_OKAY && err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_CFG;
      issued_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      last_q    <= 1'b0;
      grant_q   <= '0;
      locked_q  <= 1'b0;
      rr_ptr_q  <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      locked_q  <= locked_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/uart_console_arbiter.md
# uart_console_arbiter

Shares the AXI-Lite UART peripheral's transmit register between `NUM_REQ` on-chip byte producers, such as a debug core, a boot ROM logger and a test sequencer. It acts as an AXI-Lite write master in front of the UART. After reset it programs the baud divider once. It then turns each granted byte into one single-beat write to the UART TX data register. Arbitration is round-robin with packet locking, so lines from different producers never interleave.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of byte producers (2..8).
- `ADDR_WIDTH`, default 32: AXI address width.
- `DATA_WIDTH`, default 32: AXI data width (32 only).
- `UART_BASE`, default 32'h0000_0000: UART base address.
- `BAUD_DIV_INIT`, default 16'd868: divider written at start-up.

Ports:
- `ACLK` in 1: the only clock.
- `ARESETN` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: producer i has a byte.
- `req_data` in 8*NUM_REQ: byte for producer i, at bits [8i+7:8i].
- `req_last` in NUM_REQ: the byte ends producer i's packet.
- `req_ready` out NUM_REQ: one-hot; the byte is taken this cycle.
- `M_AXI_awaddr` out ADDR_WIDTH, `M_AXI_awprot` out 3, `M_AXI_awvalid` out 1, `M_AXI_awready` in 1.
- `M_AXI_wdata` out DATA_WIDTH, `M_AXI_wstrb` out DATA_WIDTH/8, `M_AXI_wvalid` out 1, `M_AXI_wready` in 1.
- `M_AXI_bresp` in 2, `M_AXI_bvalid` in 1, `M_AXI_bready` out 1.
- `grant_id` out $clog2(NUM_REQ): owner of the current or last transfer.
- `locked` out 1: a packet is in progress.
- `busy` out 1: state is not IDLE.
- `err_count` out 8: saturating count of non-OKAY write responses.

## Operation
States: CFG, IDLE, XFER. Reset enters CFG.

CFG:
- Issues one write of `{16'h0, BAUD_DIV_INIT}` to `UART_BASE+4`.
- Goes to IDLE when the AW, W and B handshakes are all done.

IDLE, arbitration:
- Candidates are `req_valid`, masked to the lock owner while `locked`=1.
- The winner is the first set bit at or after `rr_ptr`, searching upward and wrapping modulo NUM_REQ.
- `req_ready[winner]` is asserted combinationally (state==IDLE & candidate present).
- On the same edge the block captures `req_data`/`req_last` into a holding register, sets `grant_id`=winner, `locked`=1, and goes to XFER.

XFER:
- Writes `{24'h0, byte}` to `UART_BASE+0`.
- On completion, if the captured last bit is 1: clear `locked` and set `rr_ptr`=(grant_id+1) mod NUM_REQ. Otherwise keep the lock and leave `rr_ptr` unchanged.
- Returns to IDLE.

Write mechanics, common to CFG and XFER:
- `awvalid` and `wvalid` rise together in the first cycle of the state. The slave only accepts when both are valid.
- Each valid drops independently after its ready is sampled high.
- `bready`=1 for the whole state.
- Completion requires aw_done & w_done & (bvalid&bready). The done flags clear on state entry.
- `awprot`=3'b000 and `wstrb`=all ones.
- `awaddr`/`wdata` are stable from state entry to the handshake.

Responses:
- bresp≠2'b00 increments `err_count`, saturating at 255.
- There is no retry; the lock and pointer advance as normal.

Boundary cases:
- A lock owner that drops `req_valid` mid-packet stalls all other producers. This is intended.
- A `req_valid` arriving in XFER waits for IDLE.

## Timing
- Reset values:
  - all `M_AXI_*` valids, `bready`, `req_ready`, `locked` = 0.
  - `awaddr`, `wdata`, `wstrb`, `grant_id`, `err_count`, `rr_ptr` = 0.
  - `busy`=1 (CFG).
- Reset may assert in any state. All outputs clear immediately, the in-flight write is abandoned, and CFG re-runs after release.
- The CFG write starts on the first rising edge after `ARESETN` deasserts.
- Against the UART slave (registered ready, with bvalid on the same edge as awready/wready), each byte takes 3 cycles:
  - IDLE: capture.
  - XFER cycle 1: valids high.
  - XFER cycle 2: awready/wready/bvalid all sampled; the state completes.
- Back-to-back throughput is one byte per 3 cycles.
- No combinational path runs from `M_AXI_*` inputs to `M_AXI_*` outputs.

## Structure
- Package `uart_console_pkg`: state encoding (CFG/IDLE/XFER), `UART_TX_OFFSET`=0, `UART_BAUD_OFFSET`=4, `RESP_OKAY`=2'b00.
- Sub-module `rr_lock_arbiter`:
  - inputs: request vector, lock enable, lock owner, pointer.
  - outputs: one-hot grant and encoded index.
  - purely combinational. The pointer and lock registers stay in the top level.

## Test plan
- Reset release with no requests -> one write of 0x364 to address 0x4, `busy` falls after 3 cycles, no further AXI activity.
- Producer 0 sends bytes 0x48, 0x69 with last on 0x69 -> two writes of 0x48 and 0x69 to 0x0, each `req_ready` a single-cycle pulse, `locked` falls after the second.
- Producers 1 and 2 both hold `req_valid` with single-byte packets (last=1) and `rr_ptr`=0 -> service order 1, 2, 1, 2.
- Producer 2 mid-packet (last=0) while producer 0 requests -> producer 0 gets no `req_ready` until producer 2's last byte completes; the next grant goes to producer 0.
- Slave returns bresp=2'b10 on three writes -> `err_count`=3 and the bytes still advance; after 300 errors `err_count`=255.
- Assert `ARESETN` low during XFER cycle 1 -> valids are 0 in the same cycle; after release a fresh baud write occurs and the captured byte is never sent.
